// File: rtl/unsinttodouble_pkg.sv
// Shared FPU conversion definitions: FSM state encoding and binary64 layout.
package unsinttodouble_pkg;

    typedef enum logic [2:0] {
        get_a         = 3'd0,
        special_cases = 3'd1,
        normalise     = 3'd2,
        pack          = 3'd3,
        put_z         = 3'd4
    } state_t;

    localparam int DOUBLE_BIAS   = 1023;
    localparam int DOUBLE_MANT_W = 52;
    localparam int DOUBLE_EXP_W  = 11;

    // m must already be normalised (m[31] set); the hidden bit is dropped.
    function automatic logic [63:0] pack_double(
        input logic [DOUBLE_EXP_W-1:0] e,
        input logic [31:0]             m
    );
        logic [DOUBLE_EXP_W-1:0] be;
        be = e + DOUBLE_EXP_W'(DOUBLE_BIAS);
        return {1'b0, be, m[30:0], {(DOUBLE_MANT_W-31){1'b0}}};
    endfunction

endpackage

// File: rtl/unsinttodouble.sv
// Iterative uint32 -> IEEE-754 binary64 converter with en/complete pacing.
module unsinttodouble (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] input_a,
    output logic [63:0] output_z,
    output logic        complete
);
    import unsinttodouble_pkg::*;

    state_t             state, state_nxt;
    logic [31:0]        a, a_nxt;
    logic [31:0]        m, m_nxt;
    logic signed [11:0] e, e_nxt;
    logic [63:0]        z, z_nxt;
    logic [63:0]        output_z_nxt;
    logic               complete_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= get_a;
            a        <= '0;
            m        <= '0;
            e        <= '0;
            z        <= '0;
            output_z <= '0;
            complete <= 1'b0;
        end else if (!en) begin
            output_z <= '0;
            complete <= 1'b0;
        end else begin
            state    <= state_nxt;
            a        <= a_nxt;
            m        <= m_nxt;
            e        <= e_nxt;
            z        <= z_nxt;
            output_z <= output_z_nxt;
            complete <= complete_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        a_nxt        = a;
        m_nxt        = m;
        e_nxt        = e;
        z_nxt        = z;
        output_z_nxt = output_z;
        complete_nxt = complete;

        unique case (state)
            get_a: begin
                a_nxt        = input_a;
                complete_nxt = 1'b0;
                state_nxt    = special_cases;
            end
            special_cases: begin
                if (a == 32'd0) begin
                    z_nxt     = 64'h0;
                    state_nxt = put_z;
                end else begin
                    m_nxt     = a;
                    e_nxt     = 12'sd31;
                    state_nxt = normalise;
                end
            end
            normalise: begin
                if (m[31]) begin
                    state_nxt = pack;
                end else begin
                    m_nxt = m << 1;
                    e_nxt = e - 12'sd1;
                end
            end
            pack: begin
                z_nxt     = pack_double(e[DOUBLE_EXP_W-1:0], m);
                state_nxt = put_z;
            end
            put_z: begin
                output_z_nxt = z;
                complete_nxt = 1'b1;
                state_nxt    = get_a;
            end
            default: state_nxt = get_a;
        endcase

        // A changed operand abandons whatever conversion is in flight.
        if (input_a != a)
            state_nxt = get_a;
    end

endmodule

// File: tb/tb_unsinttodouble.sv
// Randomised and directed bench for unsinttodouble against a real-number model.
module tb_unsinttodouble;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] input_a;
    logic [63:0] output_z;
    logic        complete;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unsinttodouble dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .input_a  (input_a),
        .output_z (output_z),
        .complete (complete)
    );

    function automatic logic [63:0] ref_double(input logic [31:0] v);
        real r;
        r = real'(longint'({32'b0, v}));
        return $realtobits(r);
    endfunction

    // Edges between successive complete pulses for a steady operand.
    function automatic int ref_period(input logic [31:0] v);
        int p;
        if (v == 32'd0) return 3;
        p = 31;
        while (!v[p]) p--;
        return 5 + (31 - p);
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pulse(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (complete !== 1'b1 && n < 200);
        check_int({tag, " pulse_seen"}, int'(complete), 1);
    endtask

    task automatic convert(input string tag, input logic [31:0] v);
        int n;
        input_a = v;
        wait_pulse(tag, n);
        check64({tag, " value1"}, output_z, ref_double(v));
        wait_pulse(tag, n);
        check_int({tag, " period"}, n, ref_period(v));
        check64({tag, " value2"}, output_z, ref_double(v));
        @(negedge clk);
        check_int({tag, " pulse_width"}, int'(complete), 0);
    endtask

    initial begin
        int          n;
        int          total;
        logic        seen;
        logic [31:0] v;

        rst     = 1'b1;
        en      = 1'b1;
        input_a = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset output_z", output_z, 64'h0);
        check_int("reset complete", int'(complete), 0);
        rst = 1'b0;
        wait_pulse("after_reset", n);
        check64("after_reset value", output_z, 64'h4014000000000000);

        convert("zero", 32'd0);
        convert("one", 32'd1);
        check64("one const", output_z, 64'h3FF0000000000000);
        convert("three", 32'd3);
        check64("three const", output_z, 64'h4008000000000000);
        convert("msb", 32'h80000000);
        check64("msb const", output_z, 64'h41E0000000000000);
        convert("all_ones", 32'hFFFFFFFF);
        check64("all_ones const", output_z, 64'h41EFFFFFFFE00000);

        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            if (i % 2 == 1) v = v >> $urandom_range(0, 31);
            convert($sformatf("rand%0d", i), v);
        end

        // Operand change mid-normalise: the first conversion never completes.
        input_a = 32'd1;
        seen    = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (complete) seen = 1'b1;
        end
        check_int("restart no_pulse", int'(seen), 0);
        input_a = 32'h80000000;
        wait_pulse("restart", n);
        check64("restart value", output_z, 64'h41E0000000000000);

        // Enable gap of 5 edges mid-normalise delays completion by 5 edges.
        input_a = 32'd1;
        total   = 0;
        repeat (5) begin
            @(negedge clk);
            total++;
        end
        en   = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (output_z !== 64'h0 || complete !== 1'b0) seen = 1'b1;
        end
        check_int("en_gap outputs_cleared", int'(seen), 0);
        en = 1'b1;
        wait_pulse("en_gap", n);
        total += n;
        check64("en_gap value", output_z, 64'h3FF0000000000000);
        check_int("en_gap latency", total, 42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
